mem_port_arbiter: RTL and testbench

Shares one single-ported memory between the instruction-fetch requester and the load/store data requester of the multicycle RISC-V core. It arbitrates, launches one access at a time, counts the fixed memory read latency, and returns read data or a write acknowledge to the owning port. It sits between the control unit/datapath and the memory model, replacing direct memory drive from the FSM.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and limits for the memory port arbiter.
package mem_arb_pkg;

   localparam int unsigned RD_LAT_MIN = 1;
   localparam int unsigned RD_LAT_MAX = 4;
   localparam int unsigned CNT_W      = $clog2(RD_LAT_MAX);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      WAIT,
      RESP
   } state_t;

   typedef enum logic {
      FETCH,
      DATA
   } req_id_t;

   typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store requesters onto one single-ported memory,
// one access at a time, and returns read data or a store acknowledge.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned RD_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_rd_lat_check
      $error("mem_port_arbiter: RD_LAT must be within 1..4");
   end

   localparam cnt_t CNT_LOAD = cnt_t'(RD_LAT - 1);

   state_t              r_state;
   cnt_t                r_cnt;
   req_id_t             r_last_id;
   req_id_t             r_id;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic                r_mem_en;
   logic                r_mem_we;
   logic                r_if_rvalid;
   logic                r_d_rvalid;
   logic [DATA_W-1:0]   r_if_rdata;
   logic [DATA_W-1:0]   r_d_rdata;

   logic                w_pick_data;
   logic                w_grant;
   logic                w_if_gnt;
   logic                w_d_gnt;
   req_id_t             w_win_id;
   logic                w_win_we;
   logic [ADDR_W-1:0]   w_win_addr;

   // Arbitration in IDLE: a lone requester wins; on a tie the port not served last wins
   always_comb begin
      w_pick_data = d_req && (!if_req || (r_last_id == FETCH));
      w_grant     = (r_state == IDLE) && (if_req || d_req);
      w_if_gnt    = w_grant && !w_pick_data;
      w_d_gnt     = w_grant && w_pick_data;
      w_win_id    = w_pick_data ? DATA : FETCH;
      w_win_we    = w_pick_data && d_we;
      w_win_addr  = w_pick_data ? d_addr : if_addr;
   end

   // Transaction sequencing with registered memory strobes and response pulses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_last_id   <= FETCH;
         r_id        <= FETCH;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_if_rvalid <= 1'b0;
         r_d_rvalid  <= 1'b0;
      end else begin
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_if_rvalid <= 1'b0;
         r_d_rvalid  <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (w_grant) begin
                  r_state   <= ACCESS;
                  r_id      <= w_win_id;
                  r_last_id <= w_win_id;
                  r_we      <= w_win_we;
                  r_addr    <= w_win_addr;
                  r_wdata   <= d_wdata;
                  r_mem_en  <= 1'b1;
                  r_mem_we  <= w_win_we;
               end
            end
            ACCESS: begin
               if (r_we) begin
                  r_state     <= RESP;
                  r_if_rvalid <= (r_id == FETCH);
                  r_d_rvalid  <= (r_id == DATA);
               end else begin
                  r_state <= WAIT;
               end
            end
            WAIT: begin
               if (r_cnt == '0) begin
                  r_state     <= RESP;
                  r_if_rvalid <= (r_id == FETCH);
                  r_d_rvalid  <= (r_id == DATA);
               end
            end
            RESP: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Read latency counter: loaded as a load leaves ACCESS, counts down through WAIT
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (r_state == ACCESS && !r_we) begin
         r_cnt <= CNT_LOAD;
      end else if (r_state == WAIT && r_cnt != '0) begin
         r_cnt <= r_cnt - cnt_t'(1);
      end
   end

   // Capture returning read data into the owning port's holding register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_if_rdata <= '0;
         r_d_rdata  <= '0;
      end else if (r_state == WAIT && r_cnt == '0) begin
         if (r_id == DATA) begin
            r_d_rdata <= mem_rdata;
         end else begin
            r_if_rdata <= mem_rdata;
         end
      end
   end

   assign if_gnt    = w_if_gnt;
   assign d_gnt     = w_d_gnt;
   assign if_rvalid = r_if_rvalid;
   assign d_rvalid  = r_d_rvalid;
   assign if_rdata  = r_if_rdata;
   assign d_rdata   = r_d_rdata;
   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: four instances with RD_LAT 1..4, each with its own
// latency-accurate memory; expectations come from a transaction-level timeline.
module tb_mem_port_arbiter;

   localparam logic [63:0] POISON = 64'hBAD0_BAD0_BAD0_BAD0;

   logic        clk = 1'b0;
   logic        rst;

   logic        if_req_a    [4];
   logic [31:0] if_addr_a   [4];
   logic        if_gnt_a    [4];
   logic        if_rvalid_a [4];
   logic [63:0] if_rdata_a  [4];
   logic        d_req_a     [4];
   logic        d_we_a      [4];
   logic [31:0] d_addr_a    [4];
   logic [63:0] d_wdata_a   [4];
   logic        d_gnt_a     [4];
   logic        d_rvalid_a  [4];
   logic [63:0] d_rdata_a   [4];
   logic        mem_en_a    [4];
   logic        mem_we_a    [4];
   logic [31:0] mem_addr_a  [4];
   logic [63:0] mem_wdata_a [4];
   logic [63:0] mem_rdata_a [4];
   logic        busy_a      [4];

   logic [63:0] mem  [4][256];
   logic [63:0] pipe [4][4];

   // reference state
   logic [63:0] ref_mem   [4][256];
   logic        ref_last  [4];   // 0 = fetch served last, 1 = data
   logic [63:0] exp_if_rd [4];
   logic [63:0] exp_d_rd  [4];

   int n_checks = 0;
   int n_errors = 0;
   int cur_k    = 0;
   int cur_c    = 0;

   always #5 clk = ~clk;

   function automatic logic [63:0] init_word(input int k, input logic [7:0] i);
      if (i == 8'h10) return 64'h0000_0000_00A0_0093;
      return {32'h5EED_0000 | 32'(k), 24'h0, i};
   endfunction

   for (genvar g = 0; g < 4; g++) begin : g_dut
      mem_port_arbiter #(
         .ADDR_W(32),
         .DATA_W(64),
         .RD_LAT(g + 1)
      ) u_dut (
         .clk      (clk),
         .rst      (rst),
         .if_req   (if_req_a[g]),
         .if_addr  (if_addr_a[g]),
         .if_gnt   (if_gnt_a[g]),
         .if_rvalid(if_rvalid_a[g]),
         .if_rdata (if_rdata_a[g]),
         .d_req    (d_req_a[g]),
         .d_we     (d_we_a[g]),
         .d_addr   (d_addr_a[g]),
         .d_wdata  (d_wdata_a[g]),
         .d_gnt    (d_gnt_a[g]),
         .d_rvalid (d_rvalid_a[g]),
         .d_rdata  (d_rdata_a[g]),
         .mem_en   (mem_en_a[g]),
         .mem_we   (mem_we_a[g]),
         .mem_addr (mem_addr_a[g]),
         .mem_wdata(mem_wdata_a[g]),
         .mem_rdata(mem_rdata_a[g]),
         .busy     (busy_a[g])
      );
      // read data valid exactly RD_LAT cycles after the strobe, poison otherwise
      assign mem_rdata_a[g] = pipe[g][g];
   end

   // memory models: contents reload while reset is held
   always @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (!rst) begin
            for (int i = 0; i < 256; i++) mem[k][i] <= init_word(k, 8'(i));
         end else if (mem_en_a[k] && mem_we_a[k]) begin
            mem[k][mem_addr_a[k][7:0]] <= mem_wdata_a[k];
         end
         pipe[k][0] <= (mem_en_a[k] && !mem_we_a[k]) ? mem[k][mem_addr_a[k][7:0]] : POISON;
         for (int j = 1; j < 4; j++) pipe[k][j] <= pipe[k][j-1];
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s (inst %0d cyc %0d): observed %h expected %h", tag, cur_k, cur_c, obs, exp);
      end
   endtask

   task automatic reset_ref();
      for (int k = 0; k < 4; k++) begin
         ref_last[k]  = 1'b0;
         exp_if_rd[k] = '0;
         exp_d_rd[k]  = '0;
         for (int i = 0; i < 256; i++) ref_mem[k][i] = init_word(k, 8'(i));
      end
   endtask

   task automatic check_zero(input int k);
      cur_k = k;
      chk("zero_if_gnt",    64'(if_gnt_a[k]),    '0);
      chk("zero_d_gnt",     64'(d_gnt_a[k]),     '0);
      chk("zero_if_rvalid", 64'(if_rvalid_a[k]), '0);
      chk("zero_d_rvalid",  64'(d_rvalid_a[k]),  '0);
      chk("zero_mem_en",    64'(mem_en_a[k]),    '0);
      chk("zero_mem_we",    64'(mem_we_a[k]),    '0);
      chk("zero_busy",      64'(busy_a[k]),      '0);
      chk("zero_mem_addr",  64'(mem_addr_a[k]),  '0);
      chk("zero_mem_wdata", mem_wdata_a[k],      '0);
      chk("zero_if_rdata",  if_rdata_a[k],       '0);
      chk("zero_d_rdata",   d_rdata_a[k],        '0);
   endtask

   // One round on instance k: up to one fetch and one data request. Starts and ends
   // at a falling edge with the instance idle. Expected timeline per transaction:
   // grant g, strobe g+1, response g+2+lat (lat = RD_LAT for loads, 0 for stores),
   // the other port's grant in the IDLE cycle after that response.
   task automatic round(input int k, input bit f_on, input bit d_on, input bit f_late,
                        input logic [31:0] fa, input bit dwe, input logic [31:0] da,
                        input logic [63:0] dwd);
      int L, lat_f, lat_d, g_f, g_d, f_start, last_c, end_f, end_d;
      bit d_first;
      bit e_ifg, e_dg, e_en, e_we, e_ifv, e_dv, e_busy;
      L       = k + 1;
      lat_f   = L;
      lat_d   = dwe ? 0 : L;
      f_start = (f_late && d_on) ? 2 : 0;
      if (f_on && d_on && !f_late) d_first = (ref_last[k] == 1'b0);
      else                         d_first = d_on;
      g_f = -100;
      g_d = -100;
      if (d_first) begin
         g_d = 0;
         if (f_on) g_f = 3 + lat_d;
      end else begin
         g_f = 0;
         if (d_on) g_d = 3 + lat_f;
      end
      end_f  = f_on ? g_f + 2 + lat_f : 0;
      end_d  = d_on ? g_d + 2 + lat_d : 0;
      last_c = ((end_f > end_d) ? end_f : end_d) + 1;
      cur_k  = k;
      if_addr_a[k] = fa;
      d_addr_a[k]  = da;
      d_we_a[k]    = dwe;
      d_wdata_a[k] = dwd;
      for (int c = 0; c <= last_c; c++) begin
         cur_c = c;
         if_req_a[k] = f_on && (c >= f_start) && (c <= g_f);
         d_req_a[k]  = d_on && (c <= g_d);
         #1;
         e_ifg  = f_on && (c == g_f);
         e_dg   = d_on && (c == g_d);
         e_en   = (f_on && c == g_f + 1) || (d_on && c == g_d + 1);
         e_we   = d_on && dwe && (c == g_d + 1);
         e_ifv  = f_on && (c == end_f);
         e_dv   = d_on && (c == end_d);
         e_busy = (f_on && c > g_f && c <= end_f) || (d_on && c > g_d && c <= end_d);
         if (e_ifv)         exp_if_rd[k] = ref_mem[k][fa[7:0]];
         if (e_dv && !dwe)  exp_d_rd[k]  = ref_mem[k][da[7:0]];
         chk("if_gnt",    64'(if_gnt_a[k]),    64'(e_ifg));
         chk("d_gnt",     64'(d_gnt_a[k]),     64'(e_dg));
         chk("mem_en",    64'(mem_en_a[k]),    64'(e_en));
         chk("mem_we",    64'(mem_we_a[k]),    64'(e_we));
         chk("if_rvalid", 64'(if_rvalid_a[k]), 64'(e_ifv));
         chk("d_rvalid",  64'(d_rvalid_a[k]),  64'(e_dv));
         chk("busy",      64'(busy_a[k]),      64'(e_busy));
         chk("if_rdata",  if_rdata_a[k],       exp_if_rd[k]);
         chk("d_rdata",   d_rdata_a[k],        exp_d_rd[k]);
         if (f_on && c == g_f + 1) chk("mem_addr_f", 64'(mem_addr_a[k]), 64'(fa));
         if (d_on && c == g_d + 1) chk("mem_addr_d", 64'(mem_addr_a[k]), 64'(da));
         if (e_we) begin
            chk("mem_wdata", mem_wdata_a[k], dwd);
            ref_mem[k][da[7:0]] = dwd;
         end
         @(negedge clk);
      end
      if (f_on && d_on) ref_last[k] = d_first ? 1'b0 : 1'b1;
      else if (f_on || d_on) ref_last[k] = d_on;
   endtask

   initial begin
      int k, m;
      logic [31:0] ra_f, ra_d;
      logic [63:0] rwd;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if_req_a[i]  = 1'b0;
         if_addr_a[i] = '0;
         d_req_a[i]   = 1'b0;
         d_we_a[i]    = 1'b0;
         d_addr_a[i]  = '0;
         d_wdata_a[i] = '0;
      end
      reset_ref();
      repeat (3) @(negedge clk);
      #1;
      for (int i = 0; i < 4; i++) check_zero(i);
      rst = 1'b1;
      @(negedge clk);

      // tie straight after reset: data first, then fetch; repeated tie goes to data again
      round(1, 1'b1, 1'b1, 1'b0, 32'h20, 1'b0, 32'h40, '0);
      round(1, 1'b1, 1'b1, 1'b0, 32'h20, 1'b0, 32'h40, '0);
      // fetch only of the instruction word at 0x10
      round(1, 1'b1, 1'b0, 1'b0, 32'h10, 1'b0, '0, '0);
      // store then load of the same address
      round(1, 1'b0, 1'b1, 1'b0, '0, 1'b1, 32'h80, 64'h0000_0000_DEAD_BEEF);
      round(1, 1'b0, 1'b1, 1'b0, '0, 1'b0, 32'h80, '0);
      // fetch arriving while a load is in flight, with a load and with a store
      round(1, 1'b1, 1'b1, 1'b1, 32'h10, 1'b0, 32'h80, '0);
      round(1, 1'b1, 1'b1, 1'b1, 32'h18, 1'b1, 32'h88, 64'h1234_5678_9ABC_DEF0);

      // latency sweep on every instance
      for (int i = 0; i < 4; i++) begin
         round(i, 1'b0, 1'b1, 1'b0, '0, 1'b0, 32'h0, '0);
         round(i, 1'b0, 1'b1, 1'b0, '0, 1'b1, 32'h0, {$urandom, $urandom});
         round(i, 1'b0, 1'b1, 1'b0, '0, 1'b0, 32'h0, '0);
         round(i, 1'b1, 1'b0, 1'b0, 32'h10, 1'b0, '0, '0);
      end

      // reset in the middle of a load on the RD_LAT=2 instance
      cur_k = 1;
      cur_c = 0;
      d_addr_a[1] = 32'h30;
      d_we_a[1]   = 1'b0;
      d_req_a[1]  = 1'b1;
      #1;
      chk("abort_d_gnt", 64'(d_gnt_a[1]), 64'd1);
      @(negedge clk);
      d_req_a[1] = 1'b0;
      #1;
      chk("abort_mem_en", 64'(mem_en_a[1]), 64'd1);
      @(negedge clk);
      #1;
      chk("abort_busy", 64'(busy_a[1]), 64'd1);
      #1;
      rst = 1'b0;
      #1;
      check_zero(1);
      @(negedge clk);
      #1;
      check_zero(1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_zero(1);
      reset_ref();
      @(negedge clk);
      round(1, 1'b1, 1'b0, 1'b0, 32'h10, 1'b0, '0, '0);
      round(1, 1'b1, 1'b1, 1'b0, 32'h20, 1'b0, 32'h40, '0);

      // randomized rounds across all instances
      repeat (60) begin
         k    = int'($urandom_range(0, 3));
         m    = int'($urandom_range(0, 3));
         ra_f = 32'($urandom_range(0, 255));
         ra_d = 32'($urandom_range(0, 255));
         rwd  = {$urandom, $urandom};
         case (m)
            0:       round(k, 1'b1, 1'b0, 1'b0, ra_f, 1'b0, ra_d, rwd);
            1:       round(k, 1'b0, 1'b1, 1'b0, ra_f, 1'($urandom_range(0, 1)), ra_d, rwd);
            2:       round(k, 1'b1, 1'b1, 1'b0, ra_f, 1'($urandom_range(0, 1)), ra_d, rwd);
            default: round(k, 1'b1, 1'b1, 1'b1, ra_f, 1'($urandom_range(0, 1)), ra_d, rwd);
         endcase
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
